// File: rtl/seq_mem_arb_d1.sv
// seq_mem_arb_d1: two-port round-robin arbiter in front of a single-port
// sequential memory. One memory operation is in flight at a time, and each
// operation walks through IDLE -> ISSUE -> WAIT -> RESP.
module seq_mem_arb_d1 #(
  parameter int WIDTH    = 32,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  // requester 0
  input  logic [IDX_SIZE-1:0] p0_addr0,
  input  logic                p0_read_en,
  input  logic                p0_write_en,
  input  logic [WIDTH-1:0]    p0_in,
  output logic [WIDTH-1:0]    p0_out,
  output logic                p0_read_done,
  output logic                p0_write_done,
  // requester 1
  input  logic [IDX_SIZE-1:0] p1_addr0,
  input  logic                p1_read_en,
  input  logic                p1_write_en,
  input  logic [WIDTH-1:0]    p1_in,
  output logic [WIDTH-1:0]    p1_out,
  output logic                p1_read_done,
  output logic                p1_write_done,
  // shared memory
  output logic [IDX_SIZE-1:0] mem_addr0,
  output logic                mem_read_en,
  output logic                mem_write_en,
  output logic [WIDTH-1:0]    mem_in,
  input  logic [WIDTH-1:0]    mem_out,
  input  logic                mem_read_done,
  input  logic                mem_write_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e                         state_q, state_d;
  logic                           ptr_q, ptr_d;    // favoured port on a tie
  logic                           gnt_q, gnt_d;    // port being served
  logic                           wr_q, wr_d;      // latched op: 1 = write
  logic [IDX_SIZE-1:0]            addr_q, addr_d;
  logic [WIDTH-1:0]               data_q, data_d;
  logic [1:0][WIDTH-1:0]          out_q, out_d;    // per-port read result

  // Per-port request views, packed so the grant can index them.
  logic [1:0]                     req;
  logic [1:0]                     wr_req;
  logic [1:0][IDX_SIZE-1:0]       addr_in;
  logic [1:0][WIDTH-1:0]          data_in;
  logic                           sel;

  assign req     = {p1_read_en | p1_write_en, p0_read_en | p0_write_en};
  assign wr_req  = {p1_write_en, p0_write_en};
  assign addr_in = {p1_addr0, p0_addr0};
  assign data_in = {p1_in, p0_in};

  // Pick the winner: the pointer breaks a tie, and a lone requester always wins.
  assign sel = (&req) ? ptr_q : req[1];

  // State, grant latches and read-result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE, and memory
  // completions only in WAIT, so stray done pulses are harmless.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gnt_d   = sel;
          wr_d    = wr_req[sel];      // a write beats a read on the same port
          addr_d  = addr_in[sel];
          data_d  = data_in[sel];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wr_q ? mem_write_done : mem_read_done) begin
          state_d = S_RESP;
          if (!wr_q) out_d[gnt_q] = mem_out;
        end
      end
      S_RESP: begin
        ptr_d   = ~gnt_q;             // favour the other port next time
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The memory bus is driven only during ISSUE and stays zero otherwise.
  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr0    = '0;
    mem_in       = '0;
    if (state_q == S_ISSUE) begin
      mem_read_en  = ~wr_q;
      mem_write_en = wr_q;
      mem_addr0    = addr_q;
      mem_in       = data_q;
    end
  end

  // Completion pulses go to the granted port during RESP only.
  always_comb begin
    p0_read_done  = 1'b0;
    p0_write_done = 1'b0;
    p1_read_done  = 1'b0;
    p1_write_done = 1'b0;
    if (state_q == S_RESP) begin
      p0_read_done  = ~gnt_q & ~wr_q;
      p0_write_done = ~gnt_q &  wr_q;
      p1_read_done  =  gnt_q & ~wr_q;
      p1_write_done =  gnt_q &  wr_q;
    end
  end

  assign p0_out = out_q[0];
  assign p1_out = out_q[1];

endmodule

// File: tb/tb_seq_mem_arb_d1.sv
// Directed bench for seq_mem_arb_d1 with a small behavioural memory.
module tb_seq_mem_arb_d1;
  localparam int W = 32;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [A-1:0] p0_addr0 = '0, p1_addr0 = '0;
  logic         p0_read_en = 0, p0_write_en = 0, p1_read_en = 0, p1_write_en = 0;
  logic [W-1:0] p0_in = '0, p1_in = '0;
  logic [W-1:0] p0_out, p1_out;
  logic         p0_read_done, p0_write_done, p1_read_done, p1_write_done;
  logic [A-1:0] mem_addr0;
  logic         mem_read_en, mem_write_en;
  logic [W-1:0] mem_in, mem_out;
  logic         mem_read_done, mem_write_done;

  // Memory model: completes one cycle after the enable.
  logic [W-1:0] mem [16];
  logic         m_rd_done = 0, m_wr_done = 0;
  logic         suppress = 0, inj_rd = 0;

  assign mem_read_done  = (m_rd_done & ~suppress) | inj_rd;
  assign mem_write_done = m_wr_done & ~suppress;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mem_arb_d1 #(.WIDTH(W), .IDX_SIZE(A)) dut (
    .clk(clk), .reset(reset),
    .p0_addr0(p0_addr0), .p0_read_en(p0_read_en), .p0_write_en(p0_write_en),
    .p0_in(p0_in), .p0_out(p0_out), .p0_read_done(p0_read_done),
    .p0_write_done(p0_write_done),
    .p1_addr0(p1_addr0), .p1_read_en(p1_read_en), .p1_write_en(p1_write_en),
    .p1_in(p1_in), .p1_out(p1_out), .p1_read_done(p1_read_done),
    .p1_write_done(p1_write_done),
    .mem_addr0(mem_addr0), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_in(mem_in), .mem_out(mem_out), .mem_read_done(mem_read_done),
    .mem_write_done(mem_write_done)
  );

  // Behavioural memory, preloaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem[3]    <= 32'hDEADBEEF;
      mem[4]    <= 32'h0000_0044;
      mem[9]    <= 32'h0000_0099;
      m_rd_done <= 1'b0;
      m_wr_done <= 1'b0;
      mem_out   <= '0;
    end else begin
      if (mem_write_en) mem[mem_addr0] <= mem_in;
      if (mem_read_en)  mem_out <= mem[mem_addr0];
      m_rd_done <= mem_read_en;
      m_wr_done <= mem_write_en;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_p0_out", p0_out, 0);
    chk("rst_p1_out", p1_out, 0);
    chk("rst_mem_rd", mem_read_en, 0);
    chk("rst_mem_wr", mem_write_en, 0);
    chk("rst_p0_rdone", p0_read_done, 0);
    reset = 1'b0;
    step();

    // Single read from p0, addr 3
    p0_addr0 = 3; p0_read_en = 1;
    step();                                 // ISSUE
    chk("rd_issue_en", mem_read_en, 1);
    chk("rd_issue_wr", mem_write_en, 0);
    chk("rd_issue_addr", mem_addr0, 3);
    step();                                 // WAIT
    chk("rd_wait_en", mem_read_en, 0);
    chk("rd_wait_addr", mem_addr0, 0);
    chk("rd_wait_done", p0_read_done, 0);
    step();                                 // RESP
    chk("rd_resp_done", p0_read_done, 1);
    chk("rd_p0_out", p0_out, 32'hDEADBEEF);
    chk("rd_p1_out", p1_out, 0);
    p0_read_en = 0;
    step();                                 // IDLE
    chk("rd_done_pulse", p0_read_done, 0);

    // Simultaneous p0 write / p1 read to addr 1 after reset
    pulse_reset();
    p0_addr0 = 1; p0_in = 5; p0_write_en = 1;
    p1_addr0 = 1; p1_read_en = 1;
    step();
    chk("sim_wr_en", mem_write_en, 1);
    chk("sim_rd_en", mem_read_en, 0);
    chk("sim_addr", mem_addr0, 1);
    chk("sim_data", mem_in, 5);
    step(); step();                         // RESP
    chk("sim_p0_wdone", p0_write_done, 1);
    chk("sim_p1_rdone0", p1_read_done, 0);
    p0_write_en = 0;
    step();                                 // IDLE
    step();                                 // ISSUE for p1
    chk("sim_p1_issue", mem_read_en, 1);
    step(); step();                         // RESP
    chk("sim_p1_rdone", p1_read_done, 1);
    chk("sim_p1_out", p1_out, 5);
    p1_read_en = 0;
    step();

    // Sustained contention: both ports read continuously for 8 ops
    p0_addr0 = 4; p1_addr0 = 9;
    p0_read_en = 1; p1_read_en = 1;
    for (int k = 0; k < 8; k++) begin
      step();                               // ISSUE
      chk("rr_addr", mem_addr0, (k % 2 == 0) ? 4 : 9);
      chk("rr_overlap", mem_read_en & mem_write_en, 0);
      step();
      chk("rr_overlap_w", mem_read_en | mem_write_en, 0);
      step();                               // RESP
      chk("rr_p0_done", p0_read_done, (k % 2 == 0) ? 1 : 0);
      chk("rr_p1_done", p1_read_done, (k % 2 == 0) ? 0 : 1);
      step();                               // IDLE
    end
    p0_read_en = 0; p1_read_en = 0;
    chk("rr_p0_out", p0_out, 32'h44);
    chk("rr_p1_out", p1_out, 32'h99);
    step();

    // Same-port read and write together: write wins
    p0_addr0 = 2; p0_in = 32'h77; p0_read_en = 1; p0_write_en = 1;
    step();
    chk("rw_wr_en", mem_write_en, 1);
    chk("rw_rd_en", mem_read_en, 0);
    step(); step();
    chk("rw_wdone", p0_write_done, 1);
    chk("rw_rdone", p0_read_done, 0);
    p0_read_en = 0; p0_write_en = 0;
    step(); step();
    chk("rw_no_more", mem_read_en | mem_write_en, 0);

    // Reset in WAIT, then a late completion
    suppress = 1;
    p1_addr0 = 9; p1_read_en = 1;
    step();                                 // ISSUE (IDLE sampled before)
    step();                                 // WAIT
    #2;
    reset = 1'b1;
    #1;
    chk("rstw_p0_out", p0_out, 0);
    chk("rstw_p1_out", p1_out, 0);
    chk("rstw_mem", mem_read_en | mem_write_en | mem_addr0, 0);
    chk("rstw_done", p1_read_done | p0_read_done, 0);
    p1_read_en = 0;
    step();
    reset = 1'b0;
    step();
    inj_rd = 1;
    step();
    inj_rd = 0;
    chk("late_p1_done", p1_read_done, 0);
    step();
    chk("late_p1_done2", p1_read_done | p0_read_done, 0);
    chk("late_mem", mem_read_en | mem_write_en, 0);
    suppress = 0;
    p0_addr0 = 4; p1_addr0 = 9; p0_read_en = 1; p1_read_en = 1;
    step();
    chk("tie_after_rst", mem_addr0, 4);
    step(); step();
    chk("tie_p0_done", p0_read_done, 1);
    p0_read_en = 0; p1_read_en = 0;
    step();

    // Request dropped during WAIT still completes
    p0_addr0 = 5; p0_in = 32'hAB; p0_write_en = 1;
    step();                                 // ISSUE
    step();                                 // WAIT
    p0_write_en = 0;
    step();                                 // RESP
    chk("drop_wdone", p0_write_done, 1);
    step();
    chk("drop_idle", mem_read_en | mem_write_en, 0);
    step();
    chk("drop_no_issue", mem_read_en | mem_write_en, 0);
    p1_addr0 = 5; p1_read_en = 1;
    step(); step(); step();
    chk("drop_readback", p1_out, 32'hAB);
    p1_read_en = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mem_arb_d1.md
SEQ_MEM_ARB_D1 -- requirements
Module: seq_mem_arb_d1

Interface
REQ-001 Parameter WIDTH, default 32, data word width.
REQ-002 Parameter IDX_SIZE, default 4, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pN_addr0 (N=0,1)  input  IDX_SIZE  requester N address.
REQ-006 pN_read_en (N=0,1)  input  1  requester N read request, level, held until pN_read_done.
REQ-007 pN_write_en (N=0,1)  input  1  requester N write request, level, held until pN_write_done.
REQ-008 pN_in (N=0,1)  input  WIDTH  requester N write data.
REQ-009 pN_out (N=0,1)  output  WIDTH  requester N last read data, registered.
REQ-010 pN_read_done / pN_write_done (N=0,1)  output  1  one-cycle completion pulses.
REQ-011 mem_addr0  output  IDX_SIZE  address to the shared single-port sequential memory.
REQ-012 mem_read_en / mem_write_en  output  1  memory enables.
REQ-013 mem_in  output  WIDTH  memory write data.
REQ-014 mem_out  input  WIDTH  memory read data.
REQ-015 mem_read_done / mem_write_done  input  1  memory completion, one cycle after the enable.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; exactly one memory operation in flight at any time.
REQ-017 IDLE: a port requests when read_en|write_en is high; if any port requests, grant one and go to ISSUE; otherwise stay in IDLE.
REQ-018 Round-robin: a 1-bit priority pointer selects the favoured port on a tie; after each RESP the pointer points to the port not just served.
REQ-019 A lone requester is granted regardless of the pointer.
REQ-020 The IDLE->ISSUE edge latches grant, op, addr and data: op=write if write_en high (write wins over a simultaneous read_en on the same port), else read.
REQ-021 ISSUE (one cycle): mem_read_en or mem_write_en high per the latched op; mem_addr0 and mem_in come from the latches; then go to WAIT.
REQ-022 mem enables, mem_addr0 and mem_in are 0 in every state other than ISSUE.
REQ-023 WAIT: stay until mem_read_done (read) or mem_write_done (write); then go to RESP; mem done pulses in IDLE or RESP are ignored.
REQ-024 On the WAIT->RESP edge of a read, the granted port's pN_out loads mem_out; the other port's pN_out is unchanged.
REQ-025 RESP (one cycle): the granted port's pN_read_done or pN_write_done is high; then go to IDLE.
REQ-026 Latency from a request sampled in IDLE to the done pulse is 3 cycles; back-to-back throughput is 1 operation per 4 cycles.
REQ-027 Requesters deassert enables in the cycle after their done pulse; the arbiter samples requests only in IDLE.
REQ-028 A request withdrawn after grant still completes and still produces its done pulse.
REQ-029 Request inputs are ignored outside IDLE.

Reset
REQ-030 On reset assertion (asynchronous, any state including mid-operation): state=IDLE, priority pointer=port 0, all latches=0, pN_out=0, all done outputs and mem enables=0.
REQ-031 An in-flight memory completion arriving after reset is ignored; the interrupted requester gets no done pulse.

Verification
REQ-032 Single read: p0 read addr 3, mem_out=0xDEADBEEF -> mem_read_en high 1 cycle, p0_read_done 3 cycles after the request, p0_out=0xDEADBEEF, p1_out=0.
REQ-033 Simultaneous: p0 write addr 1 data 5 and p1 read addr 1 after reset -> p0 served first; p1 issued in the following IDLE; p1_out=5 with a behavioural memory.
REQ-034 Sustained contention: both ports continuously requesting for 8 operations -> grants alternate 0,1,0,1...; no port starves; mem enables never overlap.
REQ-035 Same-port read_en and write_en both high -> exactly one write issued, p0_write_done only, no read_done.
REQ-036 Reset asserted in WAIT -> outputs cleared same cycle without a clock edge; a late mem_read_done produces no pN_read_done; the next request is granted to port 0 on a tie.
REQ-037 Request dropped during WAIT -> operation completes, done pulse still issued, FSM returns to IDLE and issues no further operation.
